// File: rtl/cube_spawn_if.sv
// Signal bundle between the spawn scheduler and the game-side timers, LFSR and cube array.
// The master modport is the game side; the slave modport is the scheduler.
interface cube_spawn_if #(
   parameter int unsigned N_SLOTS = 5,
   parameter int unsigned X_W     = 9
);
   logic                     start;
   logic                     game_time_up;
   logic                     spawn_tick;
   logic [X_W-1:0]           cand_x;
   logic [N_SLOTS-1:0]       slot_busy;
   logic [N_SLOTS*X_W-1:0]   slot_x;
   logic [N_SLOTS-1:0]       slot_start;
   logic [X_W-1:0]           spawn_x;
   logic                     spawn_timer_en;
   logic                     playing;
   logic                     game_done;
   logic [7:0]               drop_count;

   modport master (
      output start, game_time_up, spawn_tick, cand_x, slot_busy, slot_x,
      input  slot_start, spawn_x, spawn_timer_en, playing, game_done, drop_count
   );

   modport slave (
      input  start, game_time_up, spawn_tick, cand_x, slot_busy, slot_x,
      output slot_start, spawn_x, spawn_timer_en, playing, game_done, drop_count
   );
endinterface

// File: rtl/cube_spawn_scheduler.sv
// Game phase FSM plus spawn arbitration: picks a free cube slot round-robin and
// retries the random x candidate until it clears every active cube by MIN_SEP.
module cube_spawn_scheduler #(
   parameter int unsigned N_SLOTS   = 5,
   parameter int unsigned X_W       = 9,
   parameter int unsigned MIN_SEP   = 40,
   parameter int unsigned MAX_RETRY = 3
) (
   input  logic          clk,
   input  logic          reset,
   cube_spawn_if.slave   bus
);
   localparam int unsigned PW = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;
   localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

   typedef enum logic [2:0] {
      S_IDLE, S_PLAY, S_SEL, S_CHK, S_ISSUE, S_DRAIN, S_DONE
   } state_t;

   state_t               state_q, state_d;
   logic [PW-1:0]        rr_q, rr_d, chosen_q, chosen_d;
   logic [RW-1:0]        retry_q, retry_d;
   logic [X_W-1:0]       cx_q, cx_d, spawn_x_q, spawn_x_d;
   logic [N_SLOTS-1:0]   busy_q, busy_d;
   logic [7:0]           drop_q, drop_d, drop_inc;
   logic                 done_q, done_d;

   logic                 found;
   logic [PW-1:0]        pick;
   logic                 conflict;

   assign drop_inc = (drop_q == 8'hFF) ? drop_q : drop_q + 8'd1;

   // First free slot at or after rr_q, wrapping modulo N_SLOTS.
   always_comb begin
      int unsigned idx;
      idx   = 0;
      found = 1'b0;
      pick  = '0;
      for (int unsigned i = 0; i < N_SLOTS; i++) begin
         idx = 32'(rr_q) + i;
         if (idx >= N_SLOTS) idx = idx - N_SLOTS;
         if (!found && !bus.slot_busy[idx]) begin
            found = 1'b1;
            pick  = PW'(idx);
         end
      end
   end

   // Only slots seen busy at SEL time take part in the separation check.
   always_comb begin
      logic [X_W:0] a, b, diff;
      a        = '0;
      b        = '0;
      diff     = '0;
      conflict = 1'b0;
      for (int unsigned j = 0; j < N_SLOTS; j++) begin
         a    = {1'b0, cx_q};
         b    = {1'b0, bus.slot_x[j*X_W +: X_W]};
         diff = (a >= b) ? (a - b) : (b - a);
         if (busy_q[j] && (diff < (X_W+1)'(MIN_SEP))) conflict = 1'b1;
      end
   end

   always_comb begin
      state_d   = state_q;
      rr_d      = rr_q;
      chosen_d  = chosen_q;
      retry_d   = retry_q;
      cx_d      = cx_q;
      busy_d    = busy_q;
      spawn_x_d = spawn_x_q;
      drop_d    = drop_q;
      done_d    = 1'b0;
      unique case (state_q)
         S_IDLE, S_DONE: begin
            if (bus.start) begin
               state_d = S_PLAY;
               drop_d  = '0;
               rr_d    = '0;
            end
         end
         S_PLAY: begin
            if (bus.game_time_up) begin
               state_d = S_DRAIN;
            end else if (bus.spawn_tick) begin
               state_d = S_SEL;
               cx_d    = bus.cand_x;
               retry_d = '0;
            end
         end
         S_SEL: begin
            if (bus.game_time_up) begin
               state_d = S_DRAIN;
            end else if (!found) begin
               drop_d  = drop_inc;
               state_d = S_PLAY;
            end else begin
               chosen_d = pick;
               busy_d   = bus.slot_busy;
               state_d  = S_CHK;
            end
         end
         S_CHK: begin
            if (bus.game_time_up) begin
               state_d = S_DRAIN;
            end else if (!conflict) begin
               spawn_x_d = cx_q;
               state_d   = S_ISSUE;
            end else if (retry_q < RW'(MAX_RETRY)) begin
               cx_d    = bus.cand_x;
               retry_d = retry_q + 1'b1;
            end else begin
               drop_d  = drop_inc;
               state_d = S_PLAY;
            end
         end
         S_ISSUE: begin
            rr_d    = (chosen_q == PW'(N_SLOTS - 1)) ? '0 : chosen_q + 1'b1;
            state_d = bus.game_time_up ? S_DRAIN : S_PLAY;
         end
         S_DRAIN: begin
            if (bus.slot_busy == '0) begin
               state_d = S_DONE;
               done_d  = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         rr_q      <= '0;
         chosen_q  <= '0;
         retry_q   <= '0;
         cx_q      <= '0;
         busy_q    <= '0;
         spawn_x_q <= '0;
         drop_q    <= '0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         rr_q      <= rr_d;
         chosen_q  <= chosen_d;
         retry_q   <= retry_d;
         cx_q      <= cx_d;
         busy_q    <= busy_d;
         spawn_x_q <= spawn_x_d;
         drop_q    <= drop_d;
         done_q    <= done_d;
      end
   end

   assign bus.slot_start     = (state_q == S_ISSUE) ?
                               ({{(N_SLOTS-1){1'b0}}, 1'b1} << chosen_q) : '0;
   assign bus.spawn_x        = spawn_x_q;
   assign bus.spawn_timer_en = (state_q == S_PLAY);
   assign bus.playing        = (state_q == S_PLAY) || (state_q == S_SEL) ||
                               (state_q == S_CHK)  || (state_q == S_ISSUE);
   assign bus.game_done      = done_q;
   assign bus.drop_count     = drop_q;
endmodule

// File: tb/tb_cube_spawn_scheduler.sv
// Directed bench for cube_spawn_scheduler: expected spawns are queued when a tick
// is driven and matched (slot, x, arrival cycle) when slot_start fires.
module tb_cube_spawn_scheduler;
   localparam int unsigned N = 5;
   localparam int unsigned XW = 9;

   typedef struct {
      logic [N-1:0]  oh;
      logic [XW-1:0] x;
      int unsigned   due;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   int unsigned cyc = 0;
   int unsigned n_cmp = 0;
   int unsigned n_err = 0;
   exp_t        sb[$];

   cube_spawn_if #(.N_SLOTS(N), .X_W(XW)) bus ();

   cube_spawn_scheduler #(.N_SLOTS(N), .X_W(XW), .MIN_SEP(40), .MAX_RETRY(3)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic tick(input logic [XW-1:0] c);
      bus.cand_x     = c;
      bus.spawn_tick = 1'b1;
      step();
      bus.spawn_tick = 1'b0;
   endtask

   task automatic set_x(input int unsigned slot, input logic [XW-1:0] x);
      bus.slot_x[slot*XW +: XW] = x;
   endtask

   // Every slot_start pulse must match the oldest queued expectation.
   always @(negedge clk) begin
      if (!reset && bus.slot_start !== '0) begin
         if (sb.size() == 0) begin
            chk("unexpected_start", 32'(bus.slot_start), 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("start_onehot", 32'(bus.slot_start), 32'(e.oh));
            chk("spawn_x", 32'(bus.spawn_x), 32'(e.x));
            chk("latency_cycle", cyc, e.due);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin
      bus.start = 0; bus.game_time_up = 0; bus.spawn_tick = 0;
      bus.cand_x = '0; bus.slot_busy = '0;
      for (int i = 0; i < N; i++) set_x(i, 9'd480);
      step(); step();
      chk("rst_slot_start", 32'(bus.slot_start), 0);
      chk("rst_spawn_x", 32'(bus.spawn_x), 0);
      chk("rst_drop", 32'(bus.drop_count), 0);
      chk("rst_playing", 32'(bus.playing), 0);
      chk("rst_timer_en", 32'(bus.spawn_timer_en), 0);
      reset = 0;
      step();
      chk("idle_playing", 32'(bus.playing), 0);

      bus.start = 1; step(); bus.start = 0;
      chk("play_timer_en", 32'(bus.spawn_timer_en), 1);
      chk("play_playing", 32'(bus.playing), 1);

      // First spawn: all free, rr=0 -> slot0 at x=100, 3 cycles after tick.
      sb.push_back('{5'b00001, 9'd100, cyc + 3});
      tick(9'd100);
      repeat (4) step();
      chk("spawn0_done", sb.size(), 0);
      chk("spawn_x_hold", 32'(bus.spawn_x), 100);

      bus.slot_busy = 5'b00001; set_x(0, 9'd300);
      sb.push_back('{5'b00010, 9'd250, cyc + 3});
      tick(9'd250);
      repeat (4) step();
      chk("spawn1_done", sb.size(), 0);

      // All busy: dropped, back to PLAY.
      bus.slot_busy = 5'b11111;
      tick(9'd10);
      repeat (4) step();
      chk("drop_all_busy", 32'(bus.drop_count), 1);
      chk("drop_back_play", 32'(bus.spawn_timer_en), 1);

      // Three conflicting retries then drop (rr=2 picks slot2).
      bus.slot_busy = 5'b00001; set_x(0, 9'd100);
      tick(9'd120);
      bus.cand_x = 9'd130;
      step(); step();
      bus.cand_x = 9'd90;
      step();
      bus.cand_x = 9'd110;
      step();
      chk("retry_timer_off", 32'(bus.spawn_timer_en), 0);
      step();
      chk("drop_retries", 32'(bus.drop_count), 2);
      chk("retry_back_play", 32'(bus.spawn_timer_en), 1);

      // One retry then success at tick+4.
      sb.push_back('{5'b00100, 9'd200, cyc + 4});
      tick(9'd120);
      bus.cand_x = 9'd200;
      repeat (5) step();
      chk("retry_spawn_done", sb.size(), 0);

      // rr=3: slot3 chosen; a second tick during SEL is ignored.
      bus.slot_busy = 5'b00111; set_x(1, 9'd480); set_x(2, 9'd480);
      sb.push_back('{5'b01000, 9'd300, cyc + 3});
      bus.cand_x = 9'd300; bus.spawn_tick = 1;
      step(); step();
      bus.spawn_tick = 0;
      repeat (4) step();
      chk("ignored_tick_spawn", sb.size(), 0);
      chk("ignored_tick_nodrop", 32'(bus.drop_count), 2);

      // rr=4 with slots 4 and 0 busy wraps to slot1.
      bus.slot_busy = 5'b10001; set_x(4, 9'd480);
      sb.push_back('{5'b00010, 9'd300, cyc + 3});
      tick(9'd300);
      repeat (4) step();
      chk("wrap_spawn_done", sb.size(), 0);

      // Asynchronous reset while retrying in CHK.
      bus.slot_busy = 5'b00001; set_x(0, 9'd100);
      tick(9'd100);
      step(); step();
      reset = 1; #1;
      chk("arst_slot_start", 32'(bus.slot_start), 0);
      chk("arst_spawn_x", 32'(bus.spawn_x), 0);
      chk("arst_drop", 32'(bus.drop_count), 0);
      chk("arst_playing", 32'(bus.playing), 0);
      step(); reset = 0; step();
      bus.slot_busy = '0;
      tick(9'd50);
      repeat (4) step();
      chk("post_rst_idle", 32'(bus.playing), 0);

      // New game, one drop, then time-up racing a tick.
      bus.start = 1; step(); bus.start = 0;
      bus.slot_busy = 5'b11111;
      tick(9'd10);
      repeat (3) step();
      chk("game2_drop", 32'(bus.drop_count), 1);
      bus.slot_busy = 5'b00100;
      bus.game_time_up = 1; bus.spawn_tick = 1; bus.cand_x = 9'd300;
      step();
      bus.game_time_up = 0; bus.spawn_tick = 0;
      chk("drain_timer_off", 32'(bus.spawn_timer_en), 0);
      chk("drain_playing", 32'(bus.playing), 0);
      repeat (3) step();
      chk("drain_not_done", 32'(bus.game_done), 0);
      bus.slot_busy = '0;
      step();
      chk("done_pulse", 32'(bus.game_done), 1);
      step();
      chk("done_pulse_end", 32'(bus.game_done), 0);
      chk("done_playing", 32'(bus.playing), 0);
      bus.start = 1; step(); bus.start = 0;
      chk("restart_drop_clr", 32'(bus.drop_count), 0);
      chk("restart_playing", 32'(bus.playing), 1);
      step();
      chk("sb_empty", sb.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/cube_spawn_scheduler.md
Name: cube_spawn_scheduler

Overview:
- Sequences cube spawning for the falling-cubes game.
- On each spawn tick it picks a free cube slot (round-robin over the 5 Cubo instances) and checks the random x candidate against all active cubes for horizontal separation.
- It then issues a one-cycle start pulse plus a held x position to the chosen slot.
- It owns the play/drain/done game phases. It sits between the 60 s / 0.5 s timers, the 5-bit LFSR position selector and the cube array.

Parameters:
- N_SLOTS, 5, number of cube instances arbitrated.
- X_W, 9, width of x positions.
- MIN_SEP, 40, minimum |x difference| in pixels between a new cube and any active cube.
- MAX_RETRY, 3, extra candidate samples tried after a conflict before the spawn is dropped.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-high reset
- start  in  1  level/pulse; begins a game from IDLE or DONE
- game_time_up  in  1  one-cycle pulse from the 60 s timer
- spawn_tick  in  1  one-cycle pulse from the spawn timer
- cand_x  in  X_W  random candidate x, changes every clk
- slot_busy  in  N_SLOTS  bit i high while cube i is falling/painted
- slot_x  in  N_SLOTS*X_W  packed current x of each cube, slot i at [i*X_W +: X_W]
- slot_start  out  N_SLOTS  one-hot one-cycle start pulse to chosen cube
- spawn_x  out  X_W  x for new cube; valid with and held after slot_start
- spawn_timer_en  out  1  high in PLAY; enables the spawn timer
- playing  out  1  high in PLAY or SPAWN states
- game_done  out  1  one-cycle pulse on entry to DONE
- drop_count  out  8  spawns dropped (no slot or retries exhausted), saturating

Behaviour:
- Reset (async, any state): state=IDLE. slot_start=0, spawn_x=0, rr_ptr=0, retry=0, drop_count=0. spawn_timer_en, playing and game_done are 0.
- States and transitions:
  - IDLE: start -> PLAY. Clears drop_count and sets rr_ptr=0.
  - PLAY: game_time_up -> DRAIN, with priority over spawn_tick in the same cycle. Otherwise spawn_tick -> SEL, latching cand_x into cx and setting retry=0.
  - SEL (1 cycle):
    - free = ~slot_busy. Choose the first free slot at or after rr_ptr, wrapping modulo N_SLOTS.
    - No free slot: drop_count+1 -> PLAY.
  - CHK (1 cycle):
    - Conflict if any busy slot j has |cx - slot_x[j]| < MIN_SEP. Compute the absolute difference unsigned with width X_W+1.
    - No conflict -> ISSUE.
    - Conflict with retry<MAX_RETRY: relatch cx=cand_x, retry+1, stay in CHK.
    - Conflict with retry==MAX_RETRY: drop_count+1 -> PLAY.
  - ISSUE (1 cycle): slot_start = one-hot(chosen) and spawn_x=cx. rr_ptr = chosen+1, wrapping 4->0. -> PLAY.
  - DRAIN: no spawns, spawn_timer_en=0. When slot_busy==0 -> DONE.
  - DONE: game_done high for the entry cycle only. start -> PLAY, with the same clears as from IDLE.
- Latency: spawn_tick to slot_start is exactly 3 cycles with no conflict, plus 1 cycle per retry.
- spawn_x holds its last issued value until the next ISSUE.
- slot_start is never multi-hot and is never asserted outside ISSUE.
- A spawn_tick arriving while in SEL/CHK/ISSUE is ignored and not counted as a drop.
- game_time_up during SEL/CHK aborts the spawn: next state is DRAIN and no slot_start is issued. During ISSUE, the pulse completes and DRAIN follows.
- A slot whose busy bit rises in the same cycle as SEL is treated as busy. slot_busy is sampled at SEL only. The chosen slot is not re-checked in CHK.
- drop_count saturates at 255.
- start while in PLAY/SEL/CHK/ISSUE/DRAIN is ignored.

Test Plan:
- Reset mid-CHK (drive reset during a retry) -> all outputs 0 immediately, state IDLE, no slot_start after release until start.
- start, then spawn_tick with slot_busy=0 and cand_x=100 -> slot_start=5'b00001 exactly 3 clk later, spawn_x=100. The next tick with slot0 busy gives 5'b00010.
- slot_busy=5'b11111 and spawn_tick -> no slot_start, drop_count 0->1, back to PLAY.
- Slot0 busy at x=100, cand_x sequence 120,130,90,110 (all within 40) -> 3 retries, then drop, drop_count=1. Repeat with sequence 120,200 -> slot1 started with spawn_x=200 at tick+4.
- rr_ptr=4, slots 4 and 0 busy, slot1 free -> wrap selects slot_start=5'b00010.
- game_time_up and spawn_tick in the same cycle with slot_busy=5'b00100 -> no spawn, DRAIN. After slot_busy->0, game_done pulses 1 cycle. start then re-enters PLAY with drop_count=0.
